// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register and the serializer
// controllers built on top of it.
package shift_register_pkg;

    // Operation select encoding for the shift register mode input.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_t;

    // True for the modes that move one bit and so advance the frame counter.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) ||
               (m == MODE_ROR) || (m == MODE_ROL);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Mod-N shift counter: counts shift edges and emits a registered one-cycle
// wrap pulse on the edge that completes an N-bit frame.
module shift_bit_counter #(
    parameter  int unsigned N     = 8,
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;

    // Next count and wrap pulse; the pulse defaults low so it lasts one cycle.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (inc) begin
            if (count_reg == LAST) begin
                count_next = '0;
                wrap_next  = 1'b1;
            end else begin
                count_next = count_reg + CNT_W'(1);
            end
        end
    end

    // Counter and pulse registers; the pulse register updates every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: hold, shift/rotate in both directions, parallel
// load and clear, with a frame counter flagging every N-th shift.
module shift_register_universal
    import shift_register_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             SI_R,
    input  logic             SI_L,
    input  logic [N-1:0]     I,
    output logic [N-1:0]     Q,
    output logic             SO_R,
    output logic             SO_L,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [N-1:0] q_reg;
    logic [N-1:0] q_next;
    logic         cnt_inc;
    logic         cnt_clr;

    // Mode mux for the next register value; unused codes hold.
    always_comb begin
        q_next = q_reg;
        case (mode)
            MODE_SHR:  q_next = {SI_R, q_reg[N-1:1]};
            MODE_SHL:  q_next = {q_reg[N-2:0], SI_L};
            MODE_ROR:  q_next = {q_reg[0], q_reg[N-1:1]};
            MODE_ROL:  q_next = {q_reg[N-2:0], q_reg[N-1]};
            MODE_LOAD: q_next = I;
            MODE_CLR:  q_next = '0;
            default:   q_next = q_reg;
        endcase
    end

    // Data register, gated by the clock enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= q_next;
        end
    end

    // Counter controls: load/clear restart the frame, so a wrap is suppressed.
    always_comb begin
        cnt_inc = en && is_shift_mode(mode);
        cnt_clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));
    end

    shift_bit_counter #(.N(N)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .count   (count),
        .wrap    (done)
    );

    assign Q    = q_reg;
    assign SO_R = q_reg[0];
    assign SO_L = q_reg[N-1];

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal (N=8 main instance, N=4
// instance for the short-frame case).
module tb_shift_register_universal;
    import shift_register_pkg::*;

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic       si_r;
        logic       si_l;
        logic [7:0] i;
        logic [7:0] q;
        logic [2:0] cnt;
        logic       done;
    } vec_t;

    typedef struct {
        int         idx;
        logic [7:0] q;
        logic [2:0] cnt;
        logic       done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       en      = 1'b0;
    logic [2:0] mode    = 3'b000;
    logic       si_r    = 1'b0;
    logic       si_l    = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic [7:0] q;
    logic       so_r;
    logic       so_l;
    logic [2:0] count;
    logic       done;

    logic       en4    = 1'b0;
    logic [2:0] mode4  = 3'b000;
    logic       si_l4  = 1'b0;
    logic [3:0] i4     = 4'h0;
    logic [3:0] q4;
    logic       so_r4;
    logic       so_l4;
    logic [1:0] count4;
    logic       done4;

    always #5 clk = ~clk;

    shift_register_universal #(.N(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .SI_R    (si_r),
        .SI_L    (si_l),
        .I       (i_data),
        .Q       (q),
        .SO_R    (so_r),
        .SO_L    (so_l),
        .count   (count),
        .done    (done)
    );

    shift_register_universal #(.N(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en4),
        .mode    (mode4),
        .SI_R    (1'b0),
        .SI_L    (si_l4),
        .I       (i4),
        .Q       (q4),
        .SO_R    (so_r4),
        .SO_L    (so_l4),
        .count   (count4),
        .done    (done4)
    );

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic [2:0] m, input logic sr,
                       input logic sl, input logic [7:0] d, input logic [7:0] eq,
                       input logic [2:0] ec, input logic ed);
        vec_t v;
        v.en = e; v.mode = m; v.si_r = sr; v.si_l = sl; v.i = d;
        v.q = eq; v.cnt = ec; v.done = ed;
        vecs.push_back(v);
    endtask

    // Drive one vector just after an edge, queue its expectation, check after the next edge.
    task automatic apply(input int k);
        exp_t e;
        en = vecs[k].en; mode = vecs[k].mode; si_r = vecs[k].si_r;
        si_l = vecs[k].si_l; i_data = vecs[k].i;
        e.idx = k; e.q = vecs[k].q; e.cnt = vecs[k].cnt; e.done = vecs[k].done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", k, 1, 0);
        end else begin
            e = sb.pop_front();
            check("q",     e.idx, 32'(q),     32'(e.q));
            check("so_r",  e.idx, 32'(so_r),  32'(e.q[0]));
            check("so_l",  e.idx, 32'(so_l),  32'(e.q[7]));
            check("count", e.idx, 32'(count), 32'(e.cnt));
            check("done",  e.idx, 32'(done),  32'(e.done));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // LOAD B4 then 8 SHR with SI_R=1: SO_R stream 0,0,1,0,1,1,0,1, frame completes.
        add(1, MODE_LOAD, 0, 0, 8'hB4, 8'hB4, 3'd0, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hDA, 3'd1, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hED, 3'd2, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hF6, 3'd3, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hFB, 3'd4, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hFD, 3'd5, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hFE, 3'd6, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hFF, 3'd7, 0);
        add(1, MODE_SHR,  1, 0, 8'h00, 8'hFF, 3'd0, 1);
        add(1, MODE_HOLD, 1, 0, 8'h00, 8'hFF, 3'd0, 0);
        // Mixed directions share the counter.
        add(1, MODE_LOAD, 0, 0, 8'h81, 8'h81, 3'd0, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h03, 3'd1, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'h81, 3'd2, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'hC0, 3'd3, 0);
        add(1, MODE_SHL,  0, 1, 8'h00, 8'h81, 3'd4, 0);
        // en=0 holds Q and count, then shifting resumes from count 4.
        for (int k = 0; k < 5; k++) add(0, MODE_SHR, 1, 1, 8'hFF, 8'h81, 3'd4, 0);
        add(1, MODE_SHR,  0, 0, 8'h00, 8'h40, 3'd5, 0);
        add(1, MODE_SHR,  0, 0, 8'h00, 8'h20, 3'd6, 0);
        add(1, MODE_SHR,  0, 0, 8'h00, 8'h10, 3'd7, 0);
        // LOAD at count 7 wins over the wrap; then CLR.
        add(1, MODE_LOAD, 0, 0, 8'h3C, 8'h3C, 3'd0, 0);
        add(1, MODE_CLR,  1, 1, 8'hFF, 8'h00, 3'd0, 0);
        // ROL frame, HOLD at count 7, wrap, then an en=0 edge must drop done.
        add(1, MODE_LOAD, 0, 0, 8'h01, 8'h01, 3'd0, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h02, 3'd1, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h04, 3'd2, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h08, 3'd3, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h10, 3'd4, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h20, 3'd5, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h40, 3'd6, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h80, 3'd7, 0);
        add(1, MODE_HOLD, 1, 1, 8'hFF, 8'h80, 3'd7, 0);
        add(1, MODE_ROL,  0, 0, 8'h00, 8'h01, 3'd0, 1);
        add(0, MODE_ROL,  0, 0, 8'h00, 8'h01, 3'd0, 0);
        // Reserved and HOLD codes ignore toggling serial/parallel inputs.
        add(1, MODE_LOAD, 0, 0, 8'h5A, 8'h5A, 3'd0, 0);
        add(1, MODE_SHL,  0, 0, 8'h00, 8'hB4, 3'd1, 0);
        add(1, MODE_RSVD, 1, 1, 8'hFF, 8'hB4, 3'd1, 0);
        add(1, MODE_HOLD, 0, 0, 8'h00, 8'hB4, 3'd1, 0);
        add(1, MODE_RSVD, 0, 1, 8'hAA, 8'hB4, 3'd1, 0);
        add(1, MODE_HOLD, 1, 0, 8'h55, 8'hB4, 3'd1, 0);
        // Reach Q=A5, count=5 ahead of the mid-frame reset.
        add(1, MODE_LOAD, 0, 0, 8'hB4, 8'hB4, 3'd0, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'h5A, 3'd1, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'h2D, 3'd2, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'h96, 3'd3, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'h4B, 3'd4, 0);
        add(1, MODE_ROR,  0, 0, 8'h00, 8'hA5, 3'd5, 0);

        // Reset state.
        #1;
        check("rst_q",     0, 32'(q),     32'h00);
        check("rst_count", 0, 32'(count), 32'h0);
        check("rst_done",  0, 32'(done),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) apply(k);

        // Asynchronous reset mid-frame takes effect before the next edge.
        en = 1'b1; mode = MODE_SHR; si_r = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_q",     0, 32'(q),     32'h00);
        check("async_count", 0, 32'(count), 32'h0);
        check("async_done",  0, 32'(done),  32'h0);
        @(posedge clk);
        #1;
        check("held_q",      0, 32'(q),     32'h00);
        check("held_count",  0, 32'(count), 32'h0);
        reset_n = 1'b1;
        mode = MODE_HOLD;
        @(posedge clk);
        #1;
        check("post_rst_q",  0, 32'(q),     32'h00);

        // N=4 instance: four SHL edges complete a frame.
        en4 = 1'b1; mode4 = MODE_SHL; si_l4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] eq;
            logic [1:0] ec;
            eq = 4'((1 << (k + 1)) - 1);
            ec = 2'((k + 1) % 4);
            @(posedge clk);
            #1;
            check("n4_q",     k, 32'(q4),     32'(eq));
            check("n4_count", k, 32'(count4), 32'(ec));
            check("n4_done",  k, 32'(done4),  32'(k == 3));
        end
        mode4 = MODE_HOLD;
        @(posedge clk);
        #1;
        check("n4_q_hold",    4, 32'(q4),    32'hF);
        check("n4_done_drop", 4, 32'(done4), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
